// File: rtl/param_mod_counter.sv
// Loadable up/down modulo counter with runtime limit, terminal-count and wrap flags,
// sticky overflow and an optional stop-at-terminal mode.
module param_mod_counter #(
    parameter int WIDTH      = 8,
    parameter bit STOP_AT_TC = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] modulo,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf,
    output logic             done
);

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_evt;
    logic             stop_evt;
    logic             at_term;
    logic             step;

    assign at_term      = up_dn ? (count == modulo) : (count == '0);
    assign step         = en && !clear && !load && !done;
    assign tc           = en && !clear && !load && (at_term || done);
    assign load_clamped = (load_val > modulo) ? modulo : load_val;

    // Next value of one enabled step; only consumed when step is high.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a signal unassigned and no latch is inferred.
        count_next = count;
        wrap_evt   = 1'b0;
        stop_evt   = 1'b0;
        if (up_dn) begin
            if (count < modulo) begin
                count_next = count + 1'b1;
            end else if (STOP_AT_TC) begin
                count_next = modulo;
                stop_evt   = 1'b1;
            end else begin
                count_next = '0;
                wrap_evt   = 1'b1;
            end
        end else begin
            if (count > modulo) begin
                count_next = modulo;
            end else if (count == '0) begin
                if (STOP_AT_TC) begin
                    stop_evt = 1'b1;
                end else begin
                    count_next = modulo;
                    wrap_evt   = 1'b1;
                end
            end else begin
                count_next = count - 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous reset sits in the sensitivity list.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clamped;
                done  <= 1'b0;
            end else if (step) begin
                count <= count_next;
                wrap  <= wrap_evt;
                if (stop_evt) begin
                    done <= 1'b1;
                end
            end
            // A wrap in the same cycle wins over an overflow clear request.
            if (step && wrap_evt) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter: a wrapping instance and a stop-at-terminal
// instance share all inputs; expected values are hand-computed.
module tb_param_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       up_dn;
    logic [7:0] modulo;
    logic       ovf_clr;

    logic [7:0] count_m, count_s;
    logic       tc_m, wrap_m, ovf_m, done_m;
    logic       tc_s, wrap_s, ovf_s, done_s;

    int vec_cnt = 0;
    int err_cnt = 0;

    int t1_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int t2_exp [5]  = '{2, 1, 0, 5, 4};
    int t4_exp [8]  = '{1, 2, 3, 4, 4, 4, 4, 4};

    param_mod_counter #(.WIDTH(8), .STOP_AT_TC(1'b0)) u_main (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .up_dn(up_dn), .modulo(modulo), .ovf_clr(ovf_clr),
        .count(count_m), .tc(tc_m), .wrap(wrap_m), .ovf(ovf_m), .done(done_m)
    );

    param_mod_counter #(.WIDTH(8), .STOP_AT_TC(1'b1)) u_stop (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .load(load),
        .load_val(load_val), .up_dn(up_dn), .modulo(modulo), .ovf_clr(ovf_clr),
        .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s), .done(done_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        up_dn = 1'b1; modulo = 8'd9; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(count_m), 0);
        check("rst_wrap",  int'(wrap_m),  0);
        check("rst_ovf",   int'(ovf_m),   0);
        check("rst_done_s", int'(done_s), 0);
        reset = 1'b0;

        // 1: up count with wrap at modulo 9
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t1_count", int'(count_m), t1_exp[k-1]);
            check("t1_wrap",  int'(wrap_m),  int'(k == 10));
            check("t1_ovf",   int'(ovf_m),   int'(k >= 10));
            check("t1_tc",    int'(tc_m),    int'(k == 9));
        end
        en = 1'b0;

        // 2: load 3, count down modulo 5
        load = 1'b1; load_val = 8'd3; modulo = 8'd5; up_dn = 1'b0;
        tick();
        load = 1'b0;
        check("t2_load", int'(count_m), 3);
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("t2_count", int'(count_m), t2_exp[k-1]);
            check("t2_tc",    int'(tc_m),    int'(k == 3));
            check("t2_wrap",  int'(wrap_m),  int'(k == 4));
        end
        en = 1'b0;

        // 3: load clamp, then clear beats load and en
        up_dn = 1'b1; modulo = 8'd100; load = 1'b1; load_val = 8'd200;
        tick();
        check("t3_clamp", int'(count_m), 100);
        clear = 1'b1; en = 1'b1;
        tick();
        check("t3_clr_count", int'(count_m), 0);
        check("t3_clr_ovf",   int'(ovf_m),   0);
        check("t3_clr_wrap",  int'(wrap_m),  0);
        check("t3_clr_done_s", int'(done_s), 0);
        check("t3_clr_count_s", int'(count_s), 0);
        clear = 1'b0; load = 1'b0;

        // 4: stop-at-terminal instance holds at modulo 4
        modulo = 8'd4;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("t4_count_s", int'(count_s), t4_exp[k-1]);
            check("t4_wrap_s",  int'(wrap_s),  0);
            check("t4_ovf_s",   int'(ovf_s),   0);
            check("t4_tc_s",    int'(tc_s),    int'(k >= 4));
            if (k != 4) check("t4_done_s", int'(done_s), int'(k >= 5));
        end
        en = 1'b0; load = 1'b1; load_val = 8'd0;
        tick();
        load = 1'b0;
        check("t4_reload_done_s",  int'(done_s),  0);
        check("t4_reload_count_s", int'(count_s), 0);

        // 5: modulo lowered below count while counting down, then modulo 0
        modulo = 8'd100; load = 1'b1; load_val = 8'd50;
        tick();
        load = 1'b0;
        check("t5_load", int'(count_m), 50);
        up_dn = 1'b0; modulo = 8'd20; en = 1'b1;
        tick();
        check("t5_snap_count", int'(count_m), 20);
        check("t5_snap_wrap",  int'(wrap_m),  0);
        modulo = 8'd0; up_dn = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t5_m0_count", int'(count_m), 0);
            check("t5_m0_wrap",  int'(wrap_m),  1);
            check("t5_m0_tc",    int'(tc_m),    1);
        end
        en = 1'b0;

        // 6: asynchronous reset between edges, then wrap vs ovf_clr
        modulo = 8'd9; load = 1'b1; load_val = 8'd7;
        tick();
        load = 1'b0;
        check("t6_pre_count", int'(count_m), 7);
        check("t6_pre_ovf",   int'(ovf_m),   1);
        #3 reset = 1'b1;
        #1;
        check("t6_rst_count", int'(count_m), 0);
        check("t6_rst_ovf",   int'(ovf_m),   0);
        check("t6_rst_wrap",  int'(wrap_m),  0);
        check("t6_rst_done_s", int'(done_s), 0);
        #1 reset = 1'b0;

        modulo = 8'd2; up_dn = 1'b1; load = 1'b1; load_val = 8'd2;
        tick();
        load = 1'b0;
        check("t6_load", int'(count_m), 2);
        en = 1'b1; ovf_clr = 1'b1;
        tick();
        check("t6_wrap_count", int'(count_m), 0);
        check("t6_wrap_pulse", int'(wrap_m),  1);
        check("t6_ovf_set_wins", int'(ovf_m), 1);
        en = 1'b0;
        tick();
        check("t6_ovf_cleared", int'(ovf_m),  0);
        check("t6_wrap_drop",   int'(wrap_m), 0);
        ovf_clr = 1'b0;
        check("t6_done_main",   int'(done_m), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
